// File: rtl/code_lock_ctrl_pkg.sv
// Shared definitions for the keypad lock controller.
//   state_e     : controller state encoding
//   max_int     : larger of two integers (timer sizing)
//   cnt_w       : bits needed to hold the values 0..n
//   lowest_set  : index of the lowest set bit (button priority encode)
package code_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROGRAM  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Scanning downwards leaves the lowest set index as the final value.
  function automatic int lowest_set(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/code_lock_ctrl_lock_timer.sv
// Down-counter shared by the lockout period and the auto-relock delay.
//   clk        in  rising-edge clock
//   reset      in  synchronous, active-high
//   load_i     in  load load_val_i (takes priority over counting)
//   load_val_i in  number of running cycles until done_o
//   run_i      in  count enable; count holds while low
//   done_o     out high during the last running cycle of the period
module lock_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             run_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (run_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A count of 1 marks the final cycle; a zero load (disabled timer) never fires.
  assign done_o = run_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad lock controller: digit entry, code compare, lockout after repeated
// failures, optional timed auto-relock and in-field code reprogramming.
//   clk         in  rising-edge clock
//   reset       in  synchronous, active-high
//   but         in  one-cycle digit strobes, lowest set index wins
//   open        in  one-cycle strobe: compare entry with stored code
//   relock      in  one-cycle strobe: relock (or abort programming and relock)
//   prog        in  one-cycle strobe: start reprogramming from UNLOCKED
//   lock        out 1 = locked
//   locked_out  out 1 while in LOCKOUT
//   programming out 1 while in PROGRAM
//   fail_count  out consecutive failed attempts, saturating at MAX_FAILS
module code_lock_ctrl
  import code_lock_ctrl_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int CODE_LEN    = 4,
  parameter logic [CODE_LEN*$clog2(NUM_BUTTONS)-1:0] DEFAULT_CODE = {2'd2, 2'd1, 2'd3, 2'd0},
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1024,
  parameter int RELOCK_CYC  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         but,
  input  logic                           open,
  input  logic                           relock,
  input  logic                           prog,
  output logic                           lock,
  output logic                           locked_out,
  output logic                           programming,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int DIGIT_W = $clog2(NUM_BUTTONS);
  localparam int CODE_W  = CODE_LEN * DIGIT_W;
  localparam int IDX_W   = cnt_w(CODE_LEN);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int TMR_W   = cnt_w(max_int(LOCKOUT_CYC, RELOCK_CYC));

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [CODE_W-1:0]  entry_q, entry_d;
  logic [CODE_W-1:0]  shadow_q, shadow_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic               lock_q, lo_q, prg_q;

  logic               digit_vld;
  logic [DIGIT_W-1:0] digit;
  logic               tmr_load, tmr_run, tmr_done;
  logic [TMR_W-1:0]   tmr_val;

  // Digit 0 occupies the MSBs of a code buffer.
  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] buf_v,
                                                  input logic [IDX_W-1:0]  pos,
                                                  input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    r = buf_v;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (pos == IDX_W'(i)) r[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = d;
    end
    return r;
  endfunction

  assign digit_vld = |but;
  assign digit     = DIGIT_W'(lowest_set(32'(but)));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    entry_d  = entry_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    fc_d     = fc_q;
    case (state_q)
      ST_LOCKED: begin
        // open wins over a coincident digit and judges the pre-edge entry.
        if (open) begin
          if ((idx_q == IDX_W'(CODE_LEN)) && !ovf_q && (entry_q == code_q)) begin
            state_d = ST_UNLOCKED;
            fc_d    = '0;
          end else begin
            if (fc_q != FC_W'(MAX_FAILS)) fc_d = fc_q + 1'b1;
            if (fc_d == FC_W'(MAX_FAILS)) state_d = ST_LOCKOUT;
          end
          idx_d   = '0;
          ovf_d   = 1'b0;
          entry_d = '0;
        end else if (digit_vld) begin
          if (idx_q < IDX_W'(CODE_LEN)) begin
            entry_d = put_digit(entry_q, idx_q, digit);
            idx_d   = idx_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      ST_UNLOCKED: begin
        if (prog) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
        end else if (relock || tmr_done) begin
          state_d = ST_LOCKED;
        end
      end
      ST_PROGRAM: begin
        if (relock) begin
          state_d = ST_LOCKED;
          idx_d   = '0;
        end else if (open) begin
          state_d = ST_UNLOCKED;
          idx_d   = '0;
        end else if (digit_vld) begin
          shadow_d = put_digit(shadow_q, idx_q, digit);
          if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            code_d  = shadow_d;
            state_d = ST_UNLOCKED;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_LOCKED;
          fc_d    = '0;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  // The timer reloads on every entry to UNLOCKED or LOCKOUT; PROGRAM freezes it.
  assign tmr_load = (state_d != state_q) &&
                    ((state_d == ST_UNLOCKED) || (state_d == ST_LOCKOUT));
  assign tmr_val  = (state_d == ST_LOCKOUT) ? TMR_W'(LOCKOUT_CYC) : TMR_W'(RELOCK_CYC);
  assign tmr_run  = (state_q == ST_LOCKOUT) ||
                    ((state_q == ST_UNLOCKED) && (RELOCK_CYC > 0));

  lock_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .run_i      (tmr_run),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOCKED;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      entry_q <= '0;
      code_q  <= DEFAULT_CODE;
      fc_q    <= '0;
      lock_q  <= 1'b1;
      lo_q    <= 1'b0;
      prg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      fc_q    <= fc_d;
      lock_q  <= (state_d == ST_LOCKED) || (state_d == ST_LOCKOUT);
      lo_q    <= (state_d == ST_LOCKOUT);
      prg_q   <= (state_d == ST_PROGRAM);
    end
  end

  // Shadow contents are only meaningful after CODE_LEN digits overwrite them.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign lock        = lock_q;
  assign locked_out  = lo_q;
  assign programming = prg_q;
  assign fail_count  = fc_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl: instance 0 uses default parameters,
// instance 1 enables a 16-cycle auto-relock.
module tb_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] but_s    [2];
  logic       open_s   [2];
  logic       relock_s [2];
  logic       prog_s   [2];
  logic       lock_s   [2];
  logic       lo_s     [2];
  logic       prg_s    [2];
  logic [1:0] fc_s     [2];

  int n_tests = 0;
  int n_fail  = 0;
  int k;
  int bad;

  always #5 clk = ~clk;

  code_lock_ctrl dut0 (
    .clk         (clk),
    .reset       (rst),
    .but         (but_s[0]),
    .open        (open_s[0]),
    .relock      (relock_s[0]),
    .prog        (prog_s[0]),
    .lock        (lock_s[0]),
    .locked_out  (lo_s[0]),
    .programming (prg_s[0]),
    .fail_count  (fc_s[0])
  );

  code_lock_ctrl #(
    .RELOCK_CYC (16)
  ) dut1 (
    .clk         (clk),
    .reset       (rst),
    .but         (but_s[1]),
    .open        (open_s[1]),
    .relock      (relock_s[1]),
    .prog        (prog_s[1]),
    .lock        (lock_s[1]),
    .locked_out  (lo_s[1]),
    .programming (prg_s[1]),
    .fail_count  (fc_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds the strobes for one cycle and returns at
  // the next falling edge, where the registered response is visible.
  task automatic pulse(input int s, input logic [3:0] b, input logic o,
                       input logic r, input logic p);
    but_s[s]    = b;
    open_s[s]   = o;
    relock_s[s] = r;
    prog_s[s]   = p;
    @(negedge clk);
    but_s[s]    = 4'b0;
    open_s[s]   = 1'b0;
    relock_s[s] = 1'b0;
    prog_s[s]   = 1'b0;
  endtask

  task automatic dig(input int s, input int d);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    pulse(s, oh, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic code4(input int s, input int a, input int b, input int c, input int d);
    dig(s, a);
    dig(s, b);
    dig(s, c);
    dig(s, d);
  endtask

  task automatic open_p(input int s);
    pulse(s, 4'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic relock_p(input int s);
    pulse(s, 4'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic prog_p(input int s);
    pulse(s, 4'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      but_s[s] = 4'b0; open_s[s] = 1'b0; relock_s[s] = 1'b0; prog_s[s] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_lock", lock_s[s], 1);
      check("rst_locked_out", lo_s[s], 0);
      check("rst_programming", prg_s[s], 0);
      check("rst_fail_count", fc_s[s], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Default code 2,1,3,0 unlocks one cycle after open.
    code4(0, 2, 1, 3, 0);
    check("t1_pre_open_lock", lock_s[0], 1);
    open_p(0);
    check("t1_unlock", lock_s[0], 0);
    check("t1_fc", fc_s[0], 0);
    relock_p(0);
    check("t1_relock", lock_s[0], 1);

    // Overflowed and short entries fail; entry is cleared after each open.
    code4(0, 2, 1, 3, 0);
    dig(0, 0);
    open_p(0);
    check("t3_ovf_lock", lock_s[0], 1);
    check("t3_ovf_fc", fc_s[0], 1);
    dig(0, 2); dig(0, 1); dig(0, 3);
    open_p(0);
    check("t3_short_lock", lock_s[0], 1);
    check("t3_short_fc", fc_s[0], 2);
    code4(0, 2, 1, 3, 0);
    open_p(0);
    check("t3_good_lock", lock_s[0], 0);
    check("t3_good_fc", fc_s[0], 0);
    relock_p(0);

    // Three wrong codes lead to a 1024-cycle lockout that ignores input.
    code4(0, 0, 0, 0, 0); open_p(0);
    check("t2_fc1", fc_s[0], 1);
    code4(0, 0, 0, 0, 0); open_p(0);
    check("t2_fc2", fc_s[0], 2);
    check("t2_lo_before", lo_s[0], 0);
    code4(0, 0, 0, 0, 0); open_p(0);
    check("t2_lo", lo_s[0], 1);
    check("t2_fc3", fc_s[0], 3);
    check("t2_lock", lock_s[0], 1);
    k = 1;
    bad = 0;
    while (lo_s[0] === 1'b1 && k < 2000) begin
      but_s[0]  = (k == 10) ? 4'b0100 : (k == 11) ? 4'b0010 :
                  (k == 12) ? 4'b1000 : (k == 13) ? 4'b0001 : 4'b0000;
      open_s[0] = (k == 14);
      @(negedge clk);
      if (lo_s[0] === 1'b1) begin
        k++;
        if (lock_s[0] !== 1'b1) bad++;
      end
    end
    but_s[0]  = 4'b0;
    open_s[0] = 1'b0;
    check("t2_lockout_len", k, 1024);
    check("t2_lock_held", bad, 0);
    check("t2_exit_fc", fc_s[0], 0);
    check("t2_exit_lock", lock_s[0], 1);
    code4(0, 2, 1, 3, 0); open_p(0);
    check("t2_after_unlock", lock_s[0], 0);

    // Reprogram to 3,3,1,1 from UNLOCKED.
    prog_p(0);
    check("t4_prog", prg_s[0], 1);
    check("t4_prog_lock", lock_s[0], 0);
    dig(0, 3); dig(0, 3); dig(0, 1);
    check("t4_prog_mid", prg_s[0], 1);
    dig(0, 1);
    check("t4_prog_done", prg_s[0], 0);
    check("t4_done_lock", lock_s[0], 0);
    relock_p(0);
    check("t4_relock", lock_s[0], 1);
    code4(0, 2, 1, 3, 0); open_p(0);
    check("t4_old_lock", lock_s[0], 1);
    check("t4_old_fc", fc_s[0], 1);
    code4(0, 3, 3, 1, 1); open_p(0);
    check("t4_new_lock", lock_s[0], 0);
    check("t4_new_fc", fc_s[0], 0);
    prog_p(0);
    dig(0, 0);
    relock_p(0);
    check("t4_abort_prg", prg_s[0], 0);
    check("t4_abort_lock", lock_s[0], 1);
    code4(0, 3, 3, 1, 1); open_p(0);
    check("t4_kept_code", lock_s[0], 0);
    relock_p(0);

    // Reset mid-entry restores defaults, including the factory code.
    code4(0, 0, 0, 0, 0); open_p(0);
    dig(0, 2); dig(0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_entry_lock", lock_s[0], 1);
    check("t6_entry_fc", fc_s[0], 0);
    check("t6_entry_lo", lo_s[0], 0);
    check("t6_entry_prg", prg_s[0], 0);
    rst = 1'b0;
    code4(0, 2, 1, 3, 0); open_p(0);
    check("t6_default_unlock", lock_s[0], 0);
    relock_p(0);

    // Reset mid-lockout.
    for (int i = 0; i < 3; i++) begin
      code4(0, 1, 1, 1, 1); open_p(0);
    end
    check("t6_lo_entered", lo_s[0], 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_lo_cleared", lo_s[0], 0);
    check("t6_lo_fc", fc_s[0], 0);
    check("t6_lo_lock", lock_s[0], 1);
    rst = 1'b0;
    code4(0, 2, 1, 3, 0); open_p(0);
    check("t6_lo_unlock", lock_s[0], 0);
    relock_p(0);

    // Auto-relock after 16 cycles.
    code4(1, 2, 1, 3, 0); open_p(1);
    check("t5_unlock", lock_s[1], 0);
    k = 1;
    while (lock_s[1] === 1'b0 && k < 100) begin
      @(negedge clk);
      if (lock_s[1] === 1'b0) k++;
    end
    check("t5_relock_len", k, 16);
    check("t5_relocked", lock_s[1], 1);

    // prog in the 5th unlocked cycle, paused timer, abort via open.
    code4(1, 2, 1, 3, 0); open_p(1);
    k = 1;
    while (k < 5) begin
      @(negedge clk);
      k++;
    end
    prog_p(1);
    check("t5_prog", prg_s[1], 1);
    for (int i = 0; i < 20; i++) @(negedge clk);
    check("t5_prog_paused", prg_s[1], 1);
    check("t5_prog_lock", lock_s[1], 0);
    dig(1, 3);
    open_p(1);
    check("t5_abort_prg", prg_s[1], 0);
    check("t5_abort_lock", lock_s[1], 0);
    k = 1;
    while (lock_s[1] === 1'b0 && k < 100) begin
      @(negedge clk);
      if (lock_s[1] === 1'b0) k++;
    end
    check("t5_restart_len", k, 16);
    code4(1, 2, 1, 3, 0); open_p(1);
    check("t5_code_kept", lock_s[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
